// File: rtl/irq_vector_ctl.sv
// irq_vector_ctl: edge-triggered, maskable, fixed-priority interrupt source
// for the single-cycle CPU. Produces a one-cycle INT pulse with a vector
// address in entryPoint, then holds off further interrupts until the
// handler writes EOI. Registers live on the data-memory bus so the handler
// can use plain lw/sw.
module irq_vector_ctl #(
    parameter int unsigned NUM_SRC    = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0F00,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0080,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic               MemRead,
    input  logic               MemWrite,
    output logic [31:0]        rdata,
    output logic               INT,
    output logic [31:0]        entryPoint,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        SERVICE = 2'd2
    } ctlStateE;

    // Register offsets within the block (word index, addr[3:2]).
    localparam logic [1:0] OFF_MASK    = 2'd0;
    localparam logic [1:0] OFF_PENDING = 2'd1;
    localparam logic [1:0] OFF_EOI     = 2'd2;
    localparam logic [1:0] OFF_CURRENT = 2'd3;

    ctlStateE           state;
    ctlStateE           stateNext;

    logic [NUM_SRC-1:0] irqQ;
    logic [NUM_SRC-1:0] reqEdge;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pendingNext;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] armed;
    logic [NUM_SRC-1:0] fireClr;
    logic [NUM_SRC-1:0] w1cClr;
    logic [3:0]         curId;
    logic [3:0]         pickId;
    logic               anyArmed;
    logic               launch;

    logic               regHit;
    logic [1:0]         regSel;
    logic               wrMask;
    logic               wrPending;
    logic               wrEoi;

    // Write data bits above the source count carry no meaning.
    logic               unusedWdataBits;

    // Bus decode: the block occupies one 16-byte window, word aligned only.
    assign regHit    = (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);
    assign regSel    = addr[3:2];
    assign wrMask    = MemWrite && regHit && (regSel == OFF_MASK);
    assign wrPending = MemWrite && regHit && (regSel == OFF_PENDING);
    assign wrEoi     = MemWrite && regHit && (regSel == OFF_EOI);

    assign unusedWdataBits = ^wdata[31:NUM_SRC];

    // A request is a rising edge relative to last cycle's sampled level.
    assign reqEdge  = irq & ~irqQ;
    assign armed    = pending & mask;
    assign anyArmed = |armed;
    assign launch   = (state == IDLE) && anyArmed;

    // The pulse and the in-service flag are exactly the FIRE and SERVICE
    // states, so an asynchronous reset drops them immediately.
    assign INT  = (state == FIRE);
    assign busy = (state == SERVICE);

    // Fixed priority: the lowest-numbered armed source wins.
    always_comb begin
        pickId = 4'd0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (armed[i]) begin
                pickId = 4'(i);
            end
        end
    end

    // Clear sources: the one being fired and any W1C bits. New edges are
    // OR-ed in afterwards so a coincident request is never lost.
    always_comb begin
        fireClr = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            fireClr[i] = (state == FIRE) && (curId == 4'(i));
        end
        w1cClr      = wrPending ? wdata[NUM_SRC-1:0] : '0;
        pendingNext = (pending & ~(fireClr | w1cClr)) | reqEdge;
    end

    // Next-state logic for the service handshake.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (anyArmed) begin
                    stateNext = FIRE;
                end
            end
            FIRE: begin
                stateNext = SERVICE;
            end
            SERVICE: begin
                if (wrEoi) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Request capture, pending set/clear and the mask register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqQ    <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            irqQ    <= irq;
            pending <= pendingNext;
            if (wrMask) begin
                mask <= wdata[NUM_SRC-1:0];
            end
        end
    end

    // Latch the winning id and its vector when leaving IDLE; both then hold
    // until the next launch so the CPU sees a stable vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            curId      <= 4'd0;
            entryPoint <= VEC_BASE;
        end else if (launch) begin
            curId      <= pickId;
            entryPoint <= VEC_BASE + ({28'd0, pickId} * VEC_STRIDE);
        end
    end

    // Register read mux; anything unmapped or not strobed reads as zero.
    always_comb begin
        rdata = 32'h0;
        if (MemRead && regHit) begin
            case (regSel)
                OFF_MASK:    rdata[NUM_SRC-1:0] = mask;
                OFF_PENDING: rdata[NUM_SRC-1:0] = pending;
                OFF_EOI:     rdata = 32'h0;
                OFF_CURRENT: begin
                    rdata[31]  = busy;
                    rdata[3:0] = curId;
                end
                default:     rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_vector_ctl.sv
// Testbench for irq_vector_ctl: directed scenarios followed by randomized
// traffic, all compared against a behavioural reference model.
module tb_irq_vector_ctl;

    localparam int N = 4;
    localparam logic [31:0] BASE = 32'h0000_0F00;

    logic          clk;
    logic          reset;
    logic [N-1:0]  irq;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          MemRead;
    logic          MemWrite;
    logic [31:0]   rdata;
    logic          INT;
    logic [31:0]   entryPoint;
    logic          busy;

    int checks;
    int failures;

    // Reference model state, described by what the block promises.
    logic [N-1:0] mPend;
    logic [N-1:0] mMask;
    logic [N-1:0] mIrqPrev;
    logic         mFiring;
    logic         mBusy;
    logic [3:0]   mCur;
    logic [31:0]  mEntry;

    irq_vector_ctl dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .addr       (addr),
        .wdata      (wdata),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .rdata      (rdata),
        .INT        (INT),
        .entryPoint (entryPoint),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] lowestOf(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return 4'(i);
        end
        return 4'd0;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a, input logic rd);
        logic [31:0] r;
        r = 32'h0;
        if (rd && a[31:4] == BASE[31:4] && a[1:0] == 2'b00) begin
            case (a[3:2])
                2'd0: r = {28'd0, mMask};
                2'd1: r = {28'd0, mPend};
                2'd3: r = {mBusy, 27'd0, mCur};
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    task automatic modelReset();
        mPend    = '0;
        mMask    = '0;
        mIrqPrev = '0;
        mFiring  = 1'b0;
        mBusy    = 1'b0;
        mCur     = 4'd0;
        mEntry   = 32'h0000_0080;
    endtask

    task automatic checkOutputs(input string tag);
        check({tag, "_INT"},   {31'd0, INT},  {31'd0, mFiring});
        check({tag, "_busy"},  {31'd0, busy}, {31'd0, mBusy});
        check({tag, "_entry"}, entryPoint,    mEntry);
    endtask

    // Advance one clock, updating the model from the inputs presented now.
    task automatic tick();
        logic [N-1:0] rise, clr, nPend, nMask;
        logic         hit, wrM, wrP, wrE;
        logic         nFiring, nBusy;
        logic [3:0]   nCur;
        logic [31:0]  nEntry;
        hit  = (addr[31:4] == BASE[31:4]) && (addr[1:0] == 2'b00);
        wrM  = MemWrite && hit && addr[3:2] == 2'd0;
        wrP  = MemWrite && hit && addr[3:2] == 2'd1;
        wrE  = MemWrite && hit && addr[3:2] == 2'd2;
        rise = irq & ~mIrqPrev;
        nMask = wrM ? wdata[N-1:0] : mMask;
        clr   = wrP ? wdata[N-1:0] : '0;
        if (mFiring) clr[mCur] = 1'b1;
        nPend   = (mPend & ~clr) | rise;
        nFiring = 1'b0;
        nBusy   = mBusy;
        nCur    = mCur;
        nEntry  = mEntry;
        if (mFiring) begin
            nBusy = 1'b1;
        end else if (mBusy) begin
            if (wrE) nBusy = 1'b0;
        end else if ((mPend & mMask) != '0) begin
            nFiring = 1'b1;
            nCur    = lowestOf(mPend & mMask);
            nEntry  = 32'h0000_0080 + 32'(nCur) * 32'h10;
        end
        @(posedge clk);
        #1;
        if (reset) begin
            modelReset();
        end else begin
            mPend    = nPend;
            mMask    = nMask;
            mIrqPrev = irq;
            mFiring  = nFiring;
            mBusy    = nBusy;
            mCur     = nCur;
            mEntry   = nEntry;
        end
        checkOutputs("clk");
    endtask

    task automatic busWrite(input logic [1:0] off, input logic [31:0] data);
        addr     = BASE + {28'd0, off, 2'b00};
        wdata    = data;
        MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] a);
        addr    = a;
        MemRead = 1'b1;
        #1;
        check(tag, rdata, modelRead(a, 1'b1));
        MemRead = 1'b0;
        addr    = 32'h0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        irq      = '0;
        addr     = 32'h0;
        wdata    = 32'h0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        modelReset();

        // Reset state
        tick();
        reset = 1'b0;
        check("rst_entry", entryPoint, 32'h80);
        readCheck("rst_mask", BASE + 32'h0);
        readCheck("rst_pend", BASE + 32'h4);
        readCheck("rst_cur",  BASE + 32'hC);

        // Single source: INT two clocks after the edge, one cycle wide
        busWrite(2'd0, 32'h1);
        irq = 4'b0001;
        tick();
        check("t1_noint_early", {31'd0, INT}, 32'h0);
        tick();
        check("t1_int", {31'd0, INT}, 32'h1);
        check("t1_vec", entryPoint, 32'h80);
        tick();
        check("t1_int_drop", {31'd0, INT}, 32'h0);
        addr = BASE + 32'hC; MemRead = 1'b1; #1;
        check("t1_current", rdata, 32'h8000_0000);
        MemRead = 1'b0; addr = 32'h0;
        irq = '0;
        busWrite(2'd2, 32'h0);
        check("t1_eoi_busy", {31'd0, busy}, 32'h0);

        // Simultaneous sources 1 and 2: priority, then second after EOI
        busWrite(2'd0, 32'hF);
        irq = 4'b0110;
        tick();
        tick();
        check("t2_vec1", entryPoint, 32'h90);
        tick();
        addr = BASE + 32'h4; MemRead = 1'b1; #1;
        check("t2_pend", rdata, 32'h4);
        MemRead = 1'b0; addr = 32'h0;
        irq = '0;
        busWrite(2'd2, 32'h0);
        tick();
        check("t2_int2", {31'd0, INT}, 32'h1);
        check("t2_vec2", entryPoint, 32'hA0);
        tick();
        busWrite(2'd2, 32'h0);

        // Masked source stays pending and fires once unmasked
        busWrite(2'd0, 32'h0);
        irq = 4'b1000;
        tick();
        irq = '0;
        tick();
        tick();
        check("t3_masked_noint", {31'd0, INT}, 32'h0);
        addr = BASE + 32'h4; MemRead = 1'b1; #1;
        check("t3_pend", rdata, 32'h8);
        MemRead = 1'b0; addr = 32'h0;
        busWrite(2'd0, 32'h8);
        tick();
        check("t3_int", {31'd0, INT}, 32'h1);
        check("t3_vec", entryPoint, 32'hB0);
        tick();

        // No nesting; queued request fires after EOI; EOI in IDLE ignored
        busWrite(2'd0, 32'h9);
        irq = 4'b0001;
        tick();
        irq = '0;
        tick();
        tick();
        check("t4_noint_service", {31'd0, INT}, 32'h0);
        check("t4_busy", {31'd0, busy}, 32'h1);
        busWrite(2'd2, 32'h0);
        check("t4_noint_at_idle", {31'd0, INT}, 32'h0);
        tick();
        check("t4_int_after_eoi", {31'd0, INT}, 32'h1);
        check("t4_vec", entryPoint, 32'h80);
        tick();
        busWrite(2'd2, 32'h0);
        busWrite(2'd2, 32'h0);
        tick();
        check("t4_idle_eoi_int", {31'd0, INT}, 32'h0);
        check("t4_idle_eoi_busy", {31'd0, busy}, 32'h0);

        // W1C collides with a new edge: set wins
        busWrite(2'd0, 32'h0);
        irq = 4'b0010;
        busWrite(2'd1, 32'h2);
        addr = BASE + 32'h4; MemRead = 1'b1; #1;
        check("t5_set_wins", rdata, 32'h2);
        MemRead = 1'b0; addr = 32'h0;
        irq = '0;
        busWrite(2'd1, 32'h2);
        readCheck("t5_cleared", BASE + 32'h4);
        readCheck("t5_eoi_reads0", BASE + 32'h8);
        readCheck("t5_misaligned", BASE + 32'h5);

        // Reset during FIRE drops INT immediately
        busWrite(2'd0, 32'h4);
        irq = 4'b0100;
        tick();
        tick();
        check("t6_int_before", {31'd0, INT}, 32'h1);
        irq   = '0;
        reset = 1'b1;
        #1;
        modelReset();
        check("t6_int_async", {31'd0, INT}, 32'h0);
        check("t6_busy", {31'd0, busy}, 32'h0);
        check("t6_entry", entryPoint, 32'h80);
        readCheck("t6_pend", BASE + 32'h4);
        readCheck("t6_mask", BASE + 32'h0);
        tick();
        reset = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            int op;
            logic [31:0] ra;
            irq = irq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            ra  = BASE + {28'd0, 2'($urandom), 2'b00};
            if ($urandom_range(0, 7) == 0) ra = BASE + 32'($urandom_range(0, 31)) - 32'h8;
            readCheck("rnd_read", ra);
            op = $urandom_range(0, 19);
            if (op == 0) begin
                irq   = '0;
                reset = 1'b1;
                #1;
                modelReset();
                checkOutputs("rnd_async_rst");
                tick();
                reset = 1'b0;
            end else begin
                case (op)
                    1, 2, 3:  begin addr = BASE;          wdata = $urandom; MemWrite = 1'b1; end
                    4, 5:     begin addr = BASE + 32'h4;  wdata = $urandom; MemWrite = 1'b1; end
                    6, 7, 8, 9, 10: begin addr = BASE + 32'h8; wdata = $urandom; MemWrite = 1'b1; end
                    11:       begin addr = BASE + 32'h9;  wdata = $urandom; MemWrite = 1'b1; end
                    12:       begin addr = BASE + 32'h18; wdata = $urandom; MemWrite = 1'b1; end
                    default:  begin addr = 32'h0;         wdata = 32'h0;    MemWrite = 1'b0; end
                endcase
                tick();
                MemWrite = 1'b0;
                addr     = 32'h0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
